// File: rtl/mem_arbiter_if.sv
// Bus bundle between two memory requesters, the arbiter and a single memory unit.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     r0_req;
    logic                     r0_we;
    logic                     r0_lock;
    logic [ADDRESS_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0]    r0_wdata;
    logic [2:0]               r0_ctrl;
    logic                     r0_gnt;
    logic                     r0_rvalid;
    logic [DATA_WIDTH-1:0]    r0_rdata;

    logic                     r1_req;
    logic                     r1_we;
    logic                     r1_lock;
    logic [ADDRESS_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0]    r1_wdata;
    logic [2:0]               r1_ctrl;
    logic                     r1_gnt;
    logic                     r1_rvalid;
    logic [DATA_WIDTH-1:0]    r1_rdata;

    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic [2:0]               mem_ctrl;
    logic                     mem_write_enable;
    logic [DATA_WIDTH-1:0]    mem_read_data;

    modport slave (
        input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata, r0_ctrl,
        input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_ctrl,
        input  mem_read_data,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_address, mem_write_data, mem_ctrl, mem_write_enable
    );

    modport master (
        output r0_req, r0_we, r0_lock, r0_addr, r0_wdata, r0_ctrl,
        output r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_ctrl,
        output mem_read_data,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_address, mem_write_data, mem_ctrl, mem_write_enable
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin between CPU (r0) and loader (r1) with
// lock support for read-modify-write, one access per cycle, 1-cycle read return.
module mem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e                   state_q;
    state_e                   state_d;
    logic                     ptr_q;
    logic                     ptr_d;
    logic                     gnt0_s;
    logic                     gnt1_s;
    logic                     gnt0_v_s;
    logic                     gnt1_v_s;
    logic                     rvalid0_q;
    logic                     rvalid0_d;
    logic                     rvalid1_q;
    logic                     rvalid1_d;
    logic [DATA_WIDTH-1:0]    rdata0_q;
    logic [DATA_WIDTH-1:0]    rdata0_d;
    logic [DATA_WIDTH-1:0]    rdata1_q;
    logic [DATA_WIDTH-1:0]    rdata1_d;

    // Grant decision and next state / priority pointer.
    always_comb begin
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (bus.r0_req && bus.r1_req) begin
                    gnt0_s = ~ptr_q;
                    gnt1_s = ptr_q;
                    ptr_d  = ~ptr_q;
                end else begin
                    gnt0_s = bus.r0_req;
                    gnt1_s = bus.r1_req;
                end
                if (gnt0_s && bus.r0_lock) begin
                    state_d = LOCK0;
                end else if (gnt1_s && bus.r1_lock) begin
                    state_d = LOCK1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK0: begin
                gnt0_s = bus.r0_req;
                // Dropping req or issuing an unlocked access releases ownership.
                if (!bus.r0_req || !bus.r0_lock) begin
                    state_d = IDLE;
                    ptr_d   = 1'b1;
                end else begin
                    state_d = LOCK0;
                end
            end
            LOCK1: begin
                gnt1_s = bus.r1_req;
                if (!bus.r1_req || !bus.r1_lock) begin
                    state_d = IDLE;
                    ptr_d   = 1'b0;
                end else begin
                    state_d = LOCK1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = 1'b0;
            end
        endcase
    end

    // Grants are suppressed while reset is held so the memory sees no access.
    assign gnt0_v_s = gnt0_s & rst_n;
    assign gnt1_v_s = gnt1_s & rst_n & ~gnt0_s;

    // Memory-side mux and read-return next values.
    always_comb begin
        rvalid0_d = gnt0_v_s & ~bus.r0_we;
        rvalid1_d = gnt1_v_s & ~bus.r1_we;
        rdata0_d  = rvalid0_d ? bus.mem_read_data : rdata0_q;
        rdata1_d  = rvalid1_d ? bus.mem_read_data : rdata1_q;
        if (gnt0_v_s) begin
            bus.mem_address      = bus.r0_addr;
            bus.mem_write_data   = bus.r0_wdata;
            bus.mem_ctrl         = bus.r0_ctrl;
            bus.mem_write_enable = bus.r0_we;
        end else if (gnt1_v_s) begin
            bus.mem_address      = bus.r1_addr;
            bus.mem_write_data   = bus.r1_wdata;
            bus.mem_ctrl         = bus.r1_ctrl;
            bus.mem_write_enable = bus.r1_we;
        end else begin
            bus.mem_address      = {ADDRESS_WIDTH{1'b0}};
            bus.mem_write_data   = {DATA_WIDTH{1'b0}};
            bus.mem_ctrl         = 3'b000;
            bus.mem_write_enable = 1'b0;
        end
    end

    assign bus.r0_gnt    = gnt0_v_s;
    assign bus.r1_gnt    = gnt1_v_s;
    assign bus.r0_rvalid = rvalid0_q;
    assign bus.r1_rvalid = rvalid1_q;
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;

    // State, pointer and read-return registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= {DATA_WIDTH{1'b0}};
            rdata1_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table walked cycle by cycle from
// reset, then hand-written lock-handoff and reset-during-lock sequences.
module tb_mem_arbiter;
    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam logic [31:0] W0 = 32'h0000_00AA;
    localparam logic [31:0] W1 = 32'h1111_2222;
    localparam logic [2:0]  C0 = 3'b000;
    localparam logic [2:0]  C1 = 3'b010;

    typedef struct {
        logic        req0, we0, lk0, req1, we1, lk1;
        logic [31:0] rd;
        logic        g0, g1, rv0, rv1;
        logic [31:0] rd0, rd1;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    vec_t vecs[17];

    mem_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic req0, we0, lk0, req1, we1, lk1, input logic [31:0] rd);
        bus.r0_req = req0; bus.r0_we = we0; bus.r0_lock = lk0;
        bus.r1_req = req1; bus.r1_we = we1; bus.r1_lock = lk1;
        bus.mem_read_data = rd;
    endtask

    // One cycle: drive just after posedge, check at the following negedge.
    task automatic step(input string tag, input vec_t v);
        logic [31:0] e_addr, e_wd;
        logic [2:0]  e_ctrl;
        logic        e_we;
        @(posedge clk); #1;
        drive(v.req0, v.we0, v.lk0, v.req1, v.we1, v.lk1, v.rd);
        @(negedge clk);
        if (v.g0) begin
            e_addr = A0; e_wd = W0; e_ctrl = C0; e_we = v.we0;
        end else if (v.g1) begin
            e_addr = A1; e_wd = W1; e_ctrl = C1; e_we = v.we1;
        end else begin
            e_addr = 32'h0; e_wd = 32'h0; e_ctrl = 3'b000; e_we = 1'b0;
        end
        chk({tag, " r0_gnt"}, {31'h0, bus.r0_gnt}, {31'h0, v.g0});
        chk({tag, " r1_gnt"}, {31'h0, bus.r1_gnt}, {31'h0, v.g1});
        chk({tag, " mem_we"}, {31'h0, bus.mem_write_enable}, {31'h0, e_we});
        chk({tag, " mem_addr"}, bus.mem_address, e_addr);
        chk({tag, " mem_wdata"}, bus.mem_write_data, e_wd);
        chk({tag, " mem_ctrl"}, {29'h0, bus.mem_ctrl}, {29'h0, e_ctrl});
        chk({tag, " r0_rvalid"}, {31'h0, bus.r0_rvalid}, {31'h0, v.rv0});
        chk({tag, " r1_rvalid"}, {31'h0, bus.r1_rvalid}, {31'h0, v.rv1});
        chk({tag, " r0_rdata"}, bus.r0_rdata, v.rd0);
        chk({tag, " r1_rdata"}, bus.r1_rdata, v.rd1);
    endtask

    function automatic vec_t mk(input logic req0, we0, lk0, req1, we1, lk1,
                                input logic [31:0] rd, input logic g0, g1, rv0, rv1,
                                input logic [31:0] rd0, rd1);
        vec_t v;
        v.req0 = req0; v.we0 = we0; v.lk0 = lk0;
        v.req1 = req1; v.we1 = we1; v.lk1 = lk1;
        v.rd = rd; v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1;
        v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, " r0_gnt"}, {31'h0, bus.r0_gnt}, 32'h0);
        chk({tag, " r1_gnt"}, {31'h0, bus.r1_gnt}, 32'h0);
        chk({tag, " mem_we"}, {31'h0, bus.mem_write_enable}, 32'h0);
        chk({tag, " r0_rvalid"}, {31'h0, bus.r0_rvalid}, 32'h0);
        chk({tag, " r1_rvalid"}, {31'h0, bus.r1_rvalid}, 32'h0);
        chk({tag, " r0_rdata"}, bus.r0_rdata, 32'h0);
        chk({tag, " r1_rdata"}, bus.r1_rdata, 32'h0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        // req0 we0 lk0 req1 we1 lk1 rd | g0 g1 rv0 rv1 rd0 rd1
        vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,32'h0);
        vecs[1]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'hDEADBEEF, 1'b1,1'b0,1'b0,1'b0,32'h0,32'h0);
        vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,32'hDEADBEEF,32'h0);
        vecs[3]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'hA1A10001, 1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF,32'h0);
        vecs[4]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'hA1A10002, 1'b0,1'b1,1'b1,1'b0,32'hA1A10001,32'h0);
        vecs[5]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'hA1A10003, 1'b1,1'b0,1'b0,1'b1,32'hA1A10001,32'hA1A10002);
        vecs[6]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'hA1A10004, 1'b0,1'b1,1'b1,1'b0,32'hA1A10003,32'hA1A10002);
        vecs[7]  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h000000FF, 1'b1,1'b0,1'b0,1'b1,32'hA1A10003,32'hA1A10004);
        vecs[8]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'hA1A10003,32'hA1A10004);
        vecs[9]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'hB0B00001, 1'b1,1'b0,1'b0,1'b0,32'hA1A10003,32'hA1A10004);
        vecs[10] = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'hB0B00002, 1'b1,1'b0,1'b1,1'b0,32'hB0B00001,32'hA1A10004);
        vecs[11] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'hB0B00003, 1'b0,1'b1,1'b1,1'b0,32'hB0B00002,32'hA1A10004);
        vecs[12] = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'hB0B00004, 1'b0,1'b1,1'b0,1'b1,32'hB0B00002,32'hB0B00003);
        vecs[13] = mk(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,32'hB0B00005, 1'b1,1'b0,1'b0,1'b1,32'hB0B00002,32'hB0B00004);
        vecs[14] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'hB0B00006, 1'b0,1'b0,1'b1,1'b0,32'hB0B00005,32'hB0B00004);
        vecs[15] = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'hB0B00007, 1'b0,1'b1,1'b0,1'b0,32'hB0B00005,32'hB0B00004);
        vecs[16] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,32'hB0B00005,32'hB0B00007);

        bus.r0_addr = A0; bus.r0_wdata = W0; bus.r0_ctrl = C0;
        bus.r1_addr = A1; bus.r1_wdata = W1; bus.r1_ctrl = C1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // r1 takes a locked write then unlocked read while r0 waits its turn.
        step("lk_s1", mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,32'hC0C00000, 1'b1,1'b0,1'b0,1'b0,32'hB0B00005,32'hB0B00007));
        step("lk_s2", mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,32'hC0C00009, 1'b0,1'b1,1'b1,1'b0,32'hC0C00000,32'hB0B00007));
        step("lk_s3", mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'hC0C00001, 1'b0,1'b1,1'b0,1'b0,32'hC0C00000,32'hB0B00007));
        step("lk_s4", mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'hC0C00002, 1'b1,1'b0,1'b0,1'b1,32'hC0C00000,32'hC0C00001));

        // Reset while r1 holds the lock with a read returning.
        step("rs_s5", mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'hD0D00000, 1'b0,1'b1,1'b1,1'b0,32'hC0C00002,32'hC0C00001));
        step("rs_s6", mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'hD0D00001, 1'b0,1'b1,1'b0,1'b1,32'hC0C00002,32'hD0D00000));
        rst_n = 1'b0;
        #1;
        reset_checks("rst_async");
        @(posedge clk); #1;
        reset_checks("rst_edge");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        step("rs_both", mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'hE0E00001, 1'b1,1'b0,1'b0,1'b0,32'h0,32'h0));
        step("rs_next", mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'hE0E00002, 1'b0,1'b1,1'b1,1'b0,32'hE0E00001,32'h0));
        step("rs_idle", mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,32'hE0E00001,32'hE0E00002));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
